// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU page-table walker.
package mmu_pkg;

  // Walk sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_REQ  = 3'd1,
    ST_L1_WAIT = 3'd2,
    ST_L2_REQ  = 3'd3,
    ST_L2_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } ptw_state_t;

  // Bit positions inside an in-memory PTE.
  localparam int PTE_R = 0;
  localparam int PTE_W = 1;
  localparam int PTE_V = 2;

  // 10/10/12 virtual address split.
  localparam int VPN1_HI = 31;
  localparam int VPN1_LO = 22;
  localparam int VPN0_HI = 21;
  localparam int VPN0_LO = 12;
  localparam int OFF_HI  = 11;
  localparam int OFF_LO  = 0;

  // Packs an in-memory leaf PTE into the TLB format {ppn, 10'b0, W, R}.
  function automatic logic [31:0] pte_to_tlb(input logic [31:0] mem_pte);
    return {mem_pte[31:12], 10'b0, mem_pte[PTE_W], mem_pte[PTE_R]};
  endfunction

  // A level-1 entry is usable only as a pointer: valid with no W/R bits.
  // Superpage leaves are not supported and are treated as faults.
  function automatic logic is_table_ptr(input logic [31:0] mem_pte);
    return mem_pte[PTE_V] & ~mem_pte[PTE_W] & ~mem_pte[PTE_R];
  endfunction

  // A level-2 entry must be a valid leaf with at least one permission bit.
  function automatic logic is_leaf(input logic [31:0] mem_pte);
    return mem_pte[PTE_V] & (mem_pte[PTE_W] | mem_pte[PTE_R]);
  endfunction

endpackage

// File: rtl/page_table_walker_if.sv
// PTW request/response channel towards the TLB plus the memory read port.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; the sender holds valid and its payload stable until then.
// mem_resp_valid_i is a one-cycle pulse with no ready (always accepted).
interface page_table_walker_if;
  logic        ptw_req_valid_i;
  logic        ptw_req_ready_o;
  logic [31:0] ptw_vaddr_i;
  logic        ptw_resp_valid_o;
  logic        ptw_resp_ready_i;
  logic [31:0] ptw_pte_o;
  logic        ptw_fault_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_rdata_i;

  // Walker side.
  modport slave (
    input  ptw_req_valid_i, ptw_vaddr_i, ptw_resp_ready_i,
           mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
    output ptw_req_ready_o, ptw_resp_valid_o, ptw_pte_o, ptw_fault_o,
           mem_req_valid_o, mem_addr_o
  );

  // TLB + memory side.
  modport master (
    output ptw_req_valid_i, ptw_vaddr_i, ptw_resp_ready_i,
           mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
    input  ptw_req_ready_o, ptw_resp_valid_o, ptw_pte_o, ptw_fault_o,
           mem_req_valid_o, mem_addr_o
  );
endinterface

// File: rtl/page_table_walker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  // Count increments, stopping once every bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/page_table_walker.sv
// Two-level page-table walker: accepts a TLB miss, reads the L1 and L2 PTEs
// one at a time over the memory port, and returns a packed PTE (0 = fault).
module page_table_walker
  import mmu_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [19:0]          satp_ppn_i,
  page_table_walker_if.slave   bus,
  output logic [CNT_WIDTH-1:0] walk_cnt_o,
  output logic [CNT_WIDTH-1:0] fault_cnt_o,
  output ptw_state_t           state_o
);

  ptw_state_t  state_q, state_d;
  logic [9:0]  vpn0_q, vpn0_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] pte_q, pte_d;
  logic        fault_q, fault_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        resp_hs;

  // Page offset and PTE reserved bits are never looked at by the walker.
  logic unused_bits;
  assign unused_bits = ^{bus.ptw_vaddr_i[OFF_HI:OFF_LO], bus.mem_rdata_i[11:3]};

  // State and all registered outputs; reset leaves the walker idle and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vpn0_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      pte_q        <= '0;
      fault_q      <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      vpn0_q       <= vpn0_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      pte_q        <= pte_d;
      fault_q      <= fault_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Walk sequencing: next state and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    vpn0_d       = vpn0_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    pte_d        = pte_q;
    fault_d      = fault_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    resp_hs      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ptw_req_valid_i && req_ready_q) begin
          // satp is consumed here; only VPN0 must survive to the L2 read.
          vpn0_d      = bus.ptw_vaddr_i[VPN0_HI:VPN0_LO];
          mem_addr_d  = {satp_ppn_i, bus.ptw_vaddr_i[VPN1_HI:VPN1_LO], 2'b00};
          mem_valid_d = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ST_L1_REQ;
        end
      end
      ST_L1_REQ: begin
        if (bus.mem_req_ready_i) begin
          mem_valid_d = 1'b0;
          state_d     = ST_L1_WAIT;
        end
      end
      ST_L1_WAIT: begin
        if (bus.mem_resp_valid_i) begin
          if (is_table_ptr(bus.mem_rdata_i)) begin
            mem_addr_d  = {bus.mem_rdata_i[31:12], vpn0_q, 2'b00};
            mem_valid_d = 1'b1;
            state_d     = ST_L2_REQ;
          end else begin
            pte_d        = '0;
            fault_d      = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_L2_REQ: begin
        if (bus.mem_req_ready_i) begin
          mem_valid_d = 1'b0;
          state_d     = ST_L2_WAIT;
        end
      end
      ST_L2_WAIT: begin
        if (bus.mem_resp_valid_i) begin
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
          if (is_leaf(bus.mem_rdata_i)) begin
            pte_d   = pte_to_tlb(bus.mem_rdata_i);
            fault_d = 1'b0;
          end else begin
            pte_d   = '0;
            fault_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (bus.ptw_resp_ready_i) begin
          resp_hs      = 1'b1;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ptw_req_ready_o  = req_ready_q;
  assign bus.ptw_resp_valid_o = resp_valid_q;
  assign bus.ptw_pte_o        = pte_q;
  assign bus.ptw_fault_o      = fault_q;
  assign bus.mem_req_valid_o  = mem_valid_q;
  assign bus.mem_addr_o       = mem_addr_q;
  assign state_o              = state_q;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_walk_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (resp_hs),
    .count (walk_cnt_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (resp_hs & fault_q),
    .count (fault_cnt_o)
  );

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: normal walk, L1/L2 faults, backpressure,
// reset mid-walk and counter saturation (small counter width).
module tb_page_table_walker;
  import mmu_pkg::*;

  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [19:0]   satp;
  logic [CW-1:0] walk_cnt;
  logic [CW-1:0] fault_cnt;
  ptw_state_t    state;

  page_table_walker_if bus ();

  page_table_walker #(.CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .satp_ppn_i  (satp),
    .bus         (bus),
    .walk_cnt_o  (walk_cnt),
    .fault_cnt_o (fault_cnt),
    .state_o     (state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int acc_cyc     = 0;
  int exp_walk    = 0;
  int exp_fault   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: present one request at a negedge, accepted on the next posedge.
  task automatic send_req(input logic [19:0] s, input logic [31:0] va);
    chk("req_ready_idle", 32'(bus.ptw_req_ready_o), 32'd1);
    satp                = s;
    bus.ptw_vaddr_i     = va;
    bus.ptw_req_valid_i = 1'b1;
    @(negedge clk);
    acc_cyc             = cyc;
    bus.ptw_req_valid_i = 1'b0;
    satp                = 20'hFFFFF;
    bus.ptw_vaddr_i     = 32'hFFFF_FFFF;
    chk("req_ready_drop", 32'(bus.ptw_req_ready_o), 32'd0);
  endtask

  // Memory responder: checks the read address, stalls, accepts, then answers.
  task automatic serve_mem(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] rdata, input int stall, input bit respond);
    int i;
    i = 0;
    while (bus.mem_req_valid_o !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_req_seen"}, 32'(bus.mem_req_valid_o), 32'd1);
    chk({tag, "_addr"}, bus.mem_addr_o, exp_addr);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, "_addr_hold"}, bus.mem_addr_o, exp_addr);
      chk({tag, "_valid_hold"}, 32'(bus.mem_req_valid_o), 32'd1);
      chk({tag, "_busy"}, 32'(bus.ptw_req_ready_o), 32'd0);
    end
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus.mem_req_valid_o), 32'd0);
    if (respond) begin
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = rdata;
      @(negedge clk);
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_rdata_i      = 32'h0;
    end
  endtask

  // TLB side: checks the response, stalls, accepts, then checks counters.
  task automatic get_resp(input string tag, input logic [31:0] exp_pte, input bit exp_f,
                          input int stall, input int exp_lat);
    int i;
    i = 0;
    while (bus.ptw_resp_valid_o !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_resp_seen"}, 32'(bus.ptw_resp_valid_o), 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
    chk({tag, "_pte"}, bus.ptw_pte_o, exp_pte);
    chk({tag, "_fault"}, 32'(bus.ptw_fault_o), 32'(exp_f));
    chk({tag, "_no_mem_req"}, 32'(bus.mem_req_valid_o), 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, "_pte_hold"}, bus.ptw_pte_o, exp_pte);
      chk({tag, "_valid_hold"}, 32'(bus.ptw_resp_valid_o), 32'd1);
      chk({tag, "_busy"}, 32'(bus.ptw_req_ready_o), 32'd0);
    end
    bus.ptw_resp_ready_i = 1'b1;
    @(negedge clk);
    bus.ptw_resp_ready_i = 1'b0;
    exp_walk  = (exp_walk < CNT_MAX) ? exp_walk + 1 : CNT_MAX;
    if (exp_f) exp_fault = (exp_fault < CNT_MAX) ? exp_fault + 1 : CNT_MAX;
    chk({tag, "_valid_drop"}, 32'(bus.ptw_resp_valid_o), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.ptw_req_ready_o), 32'd1);
    chk({tag, "_walk_cnt"}, 32'(walk_cnt), 32'(exp_walk));
    chk({tag, "_fault_cnt"}, 32'(fault_cnt), 32'(exp_fault));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(ST_IDLE));
    chk({tag, "_req_ready"}, 32'(bus.ptw_req_ready_o), 32'd1);
    chk({tag, "_resp_valid"}, 32'(bus.ptw_resp_valid_o), 32'd0);
    chk({tag, "_mem_valid"}, 32'(bus.mem_req_valid_o), 32'd0);
  endtask

  initial begin
    rst                  = 1'b1;
    satp                 = '0;
    bus.ptw_req_valid_i  = 1'b0;
    bus.ptw_vaddr_i      = '0;
    bus.ptw_resp_ready_i = 1'b0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_rdata_i      = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk_idle("reset");
    chk("reset_pte", bus.ptw_pte_o, 32'h0);
    chk("reset_fault", 32'(bus.ptw_fault_o), 32'd0);
    chk("reset_mem_addr", bus.mem_addr_o, 32'h0);
    chk("reset_walk_cnt", 32'(walk_cnt), 32'd0);
    chk("reset_fault_cnt", 32'(fault_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: normal walk
    send_req(20'h00010, 32'h00403ABC);
    serve_mem("t1_l1", 32'h00010004, 32'h00020004, 0, 1'b1);
    serve_mem("t1_l2", 32'h0002000C, 32'h12345007, 0, 1'b1);
    get_resp("t1", 32'h12345003, 1'b0, 0, 4);

    // 2: L1 invalid
    send_req(20'h00010, 32'h00403ABC);
    serve_mem("t2_l1", 32'h00010004, 32'h00000000, 0, 1'b1);
    get_resp("t2", 32'h0, 1'b1, 0, 2);

    // 3: L1 superpage leaf
    send_req(20'h00010, 32'h00403ABC);
    serve_mem("t3_l1", 32'h00010004, 32'h00020005, 0, 1'b1);
    get_resp("t3", 32'h0, 1'b1, 0, 2);

    // 4: L2 valid without permissions
    send_req(20'h00010, 32'h00403ABC);
    serve_mem("t4_l1", 32'h00010004, 32'h00020004, 0, 1'b1);
    serve_mem("t4_l2", 32'h0002000C, 32'h12345004, 0, 1'b1);
    get_resp("t4", 32'h0, 1'b1, 0, 4);

    // 5: backpressure on both memory reads and on the response
    send_req(20'h00ABC, 32'hFFC01123);
    serve_mem("t5_l1", 32'h00ABCFFC, 32'h00055004, 3, 1'b1);
    serve_mem("t5_l2", 32'h00055004, 32'hABCDE006, 3, 1'b1);
    get_resp("t5", 32'hABCDE002, 1'b0, 5, -1);

    // 6: reset while waiting for the L2 read, then a stale response
    send_req(20'h00010, 32'h00403ABC);
    serve_mem("t6_l1", 32'h00010004, 32'h00020004, 0, 1'b1);
    serve_mem("t6_l2", 32'h0002000C, 32'h0, 0, 1'b0);
    chk("t6_in_l2_wait", 32'(state), 32'(ST_L2_WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    exp_walk  = 0;
    exp_fault = 0;
    chk_idle("t6_after_rst");
    chk("t6_walk_cnt_clr", 32'(walk_cnt), 32'd0);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_rdata_i      = 32'h12345007;
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_rdata_i      = 32'h0;
    @(negedge clk);
    chk_idle("t6_stale");
    send_req(20'h00010, 32'h00403ABC);
    serve_mem("t6b_l1", 32'h00010004, 32'h00020004, 0, 1'b1);
    serve_mem("t6b_l2", 32'h0002000C, 32'h12345007, 0, 1'b1);
    get_resp("t6b", 32'h12345003, 1'b0, 0, 4);

    // 7: counters saturate at all-ones
    for (int n = 0; n < 8; n++) begin
      send_req(20'h00010, 32'h00403ABC);
      serve_mem("t7_l1", 32'h00010004, 32'h00000000, 0, 1'b1);
      get_resp("t7", 32'h0, 1'b1, 0, 2);
    end
    chk("t7_walk_sat", 32'(walk_cnt), 32'(CNT_MAX));
    chk("t7_fault_sat", 32'(fault_cnt), 32'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
